// File: rtl/maze_pkg.sv
// maze_pkg
//   Shared constants and types for the maze-solver memory responder.
//   MAZE_DIM  : cells per row/column (bitmap is MAZE_DIM x MAZE_DIM)
//   ADDR_W    : width of X/Y/row indices
//   CELL_FREE / CELL_WALL : bitmap cell encodings
//   sweep_state_e : restore sweeper FSM states
package maze_pkg;

    localparam int MAZE_DIM = 16;
    localparam int ADDR_W   = $clog2(MAZE_DIM);

    localparam logic CELL_FREE = 1'b0;
    localparam logic CELL_WALL = 1'b1;

    typedef logic [MAZE_DIM-1:0] row_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } sweep_state_e;

endpackage

// File: rtl/maze_restore_sweeper.sv
// maze_restore_sweeper
//   Walks the row index 0..MAZE_DIM-1 once per restore request so the
//   bitmap logic can copy the pristine image into the working bitmap,
//   one row per cycle.
//
//   state    | meaning
//   ---------+-----------------------------------------------------
//   ST_IDLE  | waiting for restore (ignored if load_en is also high)
//   ST_SWEEP | copying row row_o this cycle; done after MAZE_DIM-1
//
// Ports
//   clk_i      clock, rising edge
//   rst_i      asynchronous, active-high reset
//   restore_i  start request (sampled in ST_IDLE only)
//   load_en_i  row load in progress; blocks a simultaneous restore
//   busy_o     sweep in progress (registered)
//   copy_o     copy strobe for row row_o
//   row_o      row being copied this cycle
module maze_restore_sweeper
    import maze_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              restore_i,
    input  logic              load_en_i,
    output logic              busy_o,
    output logic              copy_o,
    output logic [ADDR_W-1:0] row_o
);

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(MAZE_DIM - 1);

    sweep_state_e      state_q;
    logic [ADDR_W-1:0] row_q;
    logic              busy_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (restore_i && !load_en_i) begin
                        state_q <= ST_SWEEP;
                        row_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    if (row_q == LAST_ROW) begin
                        state_q <= ST_IDLE;
                        row_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        row_q <= row_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    row_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Every busy cycle copies exactly one row, so the strobe is busy itself.
    assign busy_o = busy_q;
    assign copy_o = busy_q;
    assign row_o  = row_q;

endmodule

// File: rtl/maze_memory.sv
// maze_memory
//   Responder end of the maze-solver memory interface. Holds a working
//   MAZE_DIM x MAZE_DIM bitmap (1 = wall/visited, 0 = free) plus a pristine
//   image of the loaded maze; a restore sweep copies the image back into
//   the working bitmap so the solver can be rerun without reloading.
//
//   Optional feature: define MAZE_WALL_PROTECT_EN to discard solver writes
//   that target a wall in the pristine image and flag them on wr_err
//   (sticky until rst). Without it every write applies and wr_err is 0.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous, active-high reset
//   X, Y       cell column / row
//   RD         read request; D_out valid one cycle later, held otherwise
//   WR, D_in   write D_in into cell (X,Y)
//   D_out      registered read data
//   load_en    write load_data into row load_row of both bitmaps
//   load_row   row index for load
//   load_data  row image, bit i = column i
//   restore    pulse: start the image -> working bitmap sweep
//   busy       sweep in progress; all requests ignored meanwhile
//   wr_err     sticky write-protect violation
module maze_memory
    import maze_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   X,
    input  logic [ADDR_W-1:0]   Y,
    input  logic                RD,
    input  logic                WR,
    input  logic                D_in,
    output logic                D_out,
    input  logic                load_en,
    input  logic [ADDR_W-1:0]   load_row,
    input  logic [MAZE_DIM-1:0] load_data,
    input  logic                restore,
    output logic                busy,
    output logic                wr_err
);

    row_t work_q  [MAZE_DIM];
    row_t work_d  [MAZE_DIM];
    row_t image_q [MAZE_DIM];
    row_t image_d [MAZE_DIM];
    logic dout_q;
    logic dout_d;

    logic              sweep_busy;
    logic              sweep_copy;
    logic [ADDR_W-1:0] sweep_row;
    logic              wr_ok;
    logic              wr_viol;

    maze_restore_sweeper u_sweeper (
        .clk_i     (clk),
        .rst_i     (rst),
        .restore_i (restore),
        .load_en_i (load_en),
        .busy_o    (sweep_busy),
        .copy_o    (sweep_copy),
        .row_o     (sweep_row)
    );

`ifdef MAZE_WALL_PROTECT_EN
    assign wr_ok = (image_q[Y][X] == CELL_FREE);
`else
    assign wr_ok = 1'b1;
`endif

    // Priority: sweep copy > load > solver write. Reads are served next to
    // load/write and sample the working bitmap before this cycle's write.
    always_comb begin
        work_d  = work_q;
        image_d = image_q;
        dout_d  = dout_q;
        wr_viol = 1'b0;
        if (sweep_copy) begin
            work_d[sweep_row] = image_q[sweep_row];
        end else begin
            if (RD) begin
                dout_d = work_q[Y][X];
            end
            if (load_en) begin
                work_d[load_row]  = load_data;
                image_d[load_row] = load_data;
            end else if (WR) begin
                if (wr_ok) begin
                    work_d[Y][X] = D_in;
                end else begin
                    wr_viol = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < MAZE_DIM; r++) begin
                work_q[r]  <= '0;
                image_q[r] <= '0;
            end
            dout_q <= 1'b0;
        end else begin
            for (int r = 0; r < MAZE_DIM; r++) begin
                work_q[r]  <= work_d[r];
                image_q[r] <= image_d[r];
            end
            dout_q <= dout_d;
        end
    end

`ifdef MAZE_WALL_PROTECT_EN
    logic wr_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_err_q <= 1'b0;
        end else if (wr_viol) begin
            wr_err_q <= 1'b1;
        end
    end

    assign wr_err = wr_err_q;
`else
    assign wr_err = 1'b0;
`endif

    assign D_out = dout_q;
    assign busy  = sweep_busy;

endmodule
